// File: rtl/bp_gshare_nway_pkg.sv
// Shared types and constants for the bp_gshare_nway predictor: BTB entry,
// EX resolution packet, fetched instruction word and opcode values.
package bp_gshare_nway_pkg;

  localparam int XLEN = 32;
  // Widest tag the BTB entry can carry; narrower tags are stored zero-extended
  localparam int BTB_TAG_MAX = XLEN - 2;

  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;

  typedef logic [31:0] INST;

  typedef struct packed {
    logic                   valid;
    logic [BTB_TAG_MAX-1:0] tag;
    logic [XLEN-1:0]        target;
  } BTB_ENTRY;

  typedef struct packed {
    logic [XLEN-1:0] PC;
    logic            br_en;
    logic            con_br_en;
    logic            con_br_taken;
    logic [XLEN-1:0] tg_pc;
  } EX_BP_PACKET;

  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
    if (up) return (cnt == 2'b11) ? cnt : cnt + 2'd1;
    return (cnt == 2'b00) ? cnt : cnt - 2'd1;
  endfunction

  function automatic logic is_link_reg(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

endpackage

// File: rtl/bp_gshare_nway_if.sv
// Fetch-side and EX-resolution signals of bp_gshare_nway. The pipeline drives
// through the master modport; the predictor sits on the slave modport.
interface bp_gshare_nway_if #(
  parameter int FETCH_WIDTH = 2,
  parameter int UPD_WIDTH   = 2
);
  import bp_gshare_nway_pkg::*;

  logic [FETCH_WIDTH-1:0][XLEN-1:0] if_pc_in;
  INST  [FETCH_WIDTH-1:0]           inst;
  logic [FETCH_WIDTH-1:0]           valid;
  logic                             squash_en;
  EX_BP_PACKET [UPD_WIDTH-1:0]      ex_bp_packet_in;

  logic [FETCH_WIDTH-1:0]           bp_taken;
  logic [FETCH_WIDTH-1:0][XLEN-1:0] bp_pc_out;
  logic [FETCH_WIDTH-1:0][XLEN-1:0] bp_npc_out;
  logic                             bp_redirect_en;
  logic [XLEN-1:0]                  bp_redirect_pc;

  modport master (
    output if_pc_in, inst, valid, squash_en, ex_bp_packet_in,
    input  bp_taken, bp_pc_out, bp_npc_out, bp_redirect_en, bp_redirect_pc
  );

  modport slave (
    input  if_pc_in, inst, valid, squash_en, ex_bp_packet_in,
    output bp_taken, bp_pc_out, bp_npc_out, bp_redirect_en, bp_redirect_pc
  );

endinterface

// File: rtl/bp_gshare_nway_ras.sv
// bp_ras: circular return address stack, only built when BP_RAS_EN is defined.
// When full, a push overwrites the oldest entry; push+pop together replace the top.
`ifdef BP_RAS_EN
module bp_ras
  import bp_gshare_nway_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [XLEN-1:0]  stack [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W:0]   count;
  logic             do_pop;
  logic             wr_en;
  logic [PTR_W-1:0] wr_ptr;

  assign empty  = (count == '0);
  assign top    = stack[ptr];
  assign do_pop = pop && !empty;

  always_comb begin
    wr_en  = 1'b0;
    wr_ptr = ptr;
    if (!clear && push) begin
      wr_en  = 1'b1;
      wr_ptr = do_pop ? ptr : ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (clear) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && !do_pop) begin
      ptr <= ptr + PTR_W'(1);
      if (count != (PTR_W+1)'(DEPTH)) count <= count + 1'b1;
    end else if (do_pop && !push) begin
      ptr   <= ptr - PTR_W'(1);
      count <= count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) stack[wr_ptr] <= push_data;
  end

endmodule
`endif

// File: rtl/bp_gshare_nway.sv
// N-wide fetch-side predictor: tagged direct-mapped BTB plus gshare PHT, trained
// by M EX ports. Optional return address stack when BP_RAS_EN is defined.
module bp_gshare_nway
  import bp_gshare_nway_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int UPD_WIDTH   = 2,
  parameter int BTB_ENTRIES = 32,
  parameter int PHT_ENTRIES = 256,
  parameter int GHR_BITS    = 8,
  parameter int TAG_BITS    = 10,
  parameter int RAS_DEPTH   = 8
) (
  input  logic             clock,
  input  logic             reset,
  bp_gshare_nway_if.slave  bus
);

  localparam int BTB_IDX = $clog2(BTB_ENTRIES);
  localparam int PHT_IDX = $clog2(PHT_ENTRIES);

  BTB_ENTRY              btb [BTB_ENTRIES];
  logic [1:0]            pht [PHT_ENTRIES];
  logic [GHR_BITS-1:0]   ghr;

  logic [FETCH_WIDTH-1:0]           slot_cand;
  logic [FETCH_WIDTH-1:0]           slot_taken;
  logic [FETCH_WIDTH-1:0][XLEN-1:0] slot_npc;
  logic [FETCH_WIDTH-1:0][XLEN-1:0] btb_target;
  logic [FETCH_WIDTH-1:0][XLEN-1:0] pc_plus4;
  logic                             found;

  logic [UPD_WIDTH-1:0]              upd_cond;
  logic [UPD_WIDTH-1:0]              upd_btb;
  logic [UPD_WIDTH-1:0][PHT_IDX-1:0] upd_pidx;
  logic [UPD_WIDTH-1:0][1:0]         upd_cnt;
  logic [UPD_WIDTH-1:0][BTB_IDX-1:0] upd_bidx;
  BTB_ENTRY [UPD_WIDTH-1:0]          upd_entry;
  logic [GHR_BITS-1:0]               ghr_walk;
  logic [1:0]                        cnt_walk;
  EX_BP_PACKET                       pkt_walk;

  logic unused_inputs;
  assign unused_inputs = ^{bus.inst, bus.if_pc_in, bus.ex_bp_packet_in, bus.squash_en};

  for (genvar s = 0; s < FETCH_WIDTH; s++) begin : g_slot
    logic [XLEN-1:0]    pc;
    logic [BTB_IDX-1:0] bidx;
    logic [TAG_BITS-1:0] tag;
    logic [PHT_IDX-1:0] pidx;
    logic [6:0]         opc;
    BTB_ENTRY           ent;
    logic               hit;

    assign pc   = bus.if_pc_in[s];
    assign bidx = pc[2 +: BTB_IDX];
    assign tag  = pc[2 + BTB_IDX +: TAG_BITS];
    assign pidx = pc[2 +: PHT_IDX] ^ PHT_IDX'(ghr);
    assign opc  = bus.inst[s][6:0];
    assign ent  = btb[bidx];
    assign hit  = ent.valid && (ent.tag == BTB_TAG_MAX'(tag));

    assign pc_plus4[s]   = pc + XLEN'(4);
    assign btb_target[s] = ent.target;
    assign slot_cand[s]  = bus.valid[s] && hit &&
                           ((opc == OP_JAL) || (opc == OP_JALR) ||
                            ((opc == OP_BRANCH) && pht[pidx][1]));
  end

`ifdef BP_RAS_EN
  logic [FETCH_WIDTH-1:0] is_call;
  logic [FETCH_WIDTH-1:0] is_ret;
  logic                   pend_push;
  logic [XLEN-1:0]        pend_data;
  logic                   ras_pop;
  logic [XLEN-1:0]        ras_top;
  logic                   ras_empty;

  for (genvar s = 0; s < FETCH_WIDTH; s++) begin : g_ras_dec
    assign is_call[s] = bus.valid[s] && (bus.inst[s][6:0] == OP_JAL) &&
                        is_link_reg(bus.inst[s][11:7]);
    assign is_ret[s]  = bus.valid[s] && (bus.inst[s][6:0] == OP_JALR) &&
                        is_link_reg(bus.inst[s][19:15]) && (bus.inst[s][11:7] == 5'd0);
  end

  bp_ras #(.DEPTH(RAS_DEPTH)) u_ras (
    .clock     (clock),
    .reset     (reset),
    .clear     (bus.squash_en),
    .push      (pend_push),
    .pop       (ras_pop),
    .push_data (pend_data),
    .top       (ras_top),
    .empty     (ras_empty)
  );
`else
  localparam int unused_ras_depth = RAS_DEPTH;
`endif

  // Walk slots in order; the first taken slot masks everything above it.
  // A return after a same-group call takes the call's PC+4 and cancels the push;
  // of several untaken calls in one group only the last one is kept.
  always_comb begin
    found = 1'b0;
`ifdef BP_RAS_EN
    pend_push = 1'b0;
    pend_data = '0;
    ras_pop   = 1'b0;
`endif
    for (int s = 0; s < FETCH_WIDTH; s++) begin
      slot_taken[s] = 1'b0;
      slot_npc[s]   = pc_plus4[s];
      if (!found) begin
`ifdef BP_RAS_EN
        if (is_ret[s] && pend_push) begin
          slot_taken[s] = 1'b1;
          slot_npc[s]   = pend_data;
          pend_push     = 1'b0;
        end else if (is_ret[s] && !ras_empty) begin
          slot_taken[s] = 1'b1;
          slot_npc[s]   = ras_top;
          ras_pop       = 1'b1;
        end else
`endif
        if (slot_cand[s]) begin
          slot_taken[s] = 1'b1;
          slot_npc[s]   = btb_target[s];
        end
`ifdef BP_RAS_EN
        if (is_call[s]) begin
          pend_push = 1'b1;
          pend_data = pc_plus4[s];
        end
`endif
        found = slot_taken[s];
      end
    end
  end

  always_comb begin
    bus.bp_redirect_pc = '0;
    for (int s = FETCH_WIDTH - 1; s >= 0; s--) begin
      if (slot_taken[s]) bus.bp_redirect_pc = slot_npc[s];
    end
  end

  assign bus.bp_taken       = slot_taken;
  assign bus.bp_npc_out     = slot_npc;
  assign bus.bp_pc_out      = bus.if_pc_in;
  assign bus.bp_redirect_en = |slot_taken;

  // Ports apply in order: each sees the GHR and any counter already stepped by lower ports.
  always_comb begin
    ghr_walk = ghr;
    cnt_walk = 2'b00;
    pkt_walk = '0;
    for (int p = 0; p < UPD_WIDTH; p++) begin
      pkt_walk     = bus.ex_bp_packet_in[p];
      upd_cond[p]  = pkt_walk.br_en && pkt_walk.con_br_en;
      upd_btb[p]   = pkt_walk.br_en && (!pkt_walk.con_br_en || pkt_walk.con_br_taken);
      upd_bidx[p]  = pkt_walk.PC[2 +: BTB_IDX];
      upd_pidx[p]  = pkt_walk.PC[2 +: PHT_IDX] ^ PHT_IDX'(ghr_walk);
      upd_entry[p] = '{valid:  1'b1,
                       tag:    BTB_TAG_MAX'(pkt_walk.PC[2 + BTB_IDX +: TAG_BITS]),
                       target: pkt_walk.tg_pc};
      cnt_walk = pht[upd_pidx[p]];
      for (int q = 0; q < p; q++) begin
        if (upd_cond[q] && (upd_pidx[q] == upd_pidx[p])) cnt_walk = upd_cnt[q];
      end
      upd_cnt[p] = sat_step(cnt_walk, pkt_walk.con_br_taken);
      if (upd_cond[p]) ghr_walk = GHR_BITS'({ghr_walk, pkt_walk.con_br_taken});
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ghr <= '0;
    else        ghr <= ghr_walk;
  end

  // Later ports overwrite earlier ones, so the highest port's value lands.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= 2'b01;
    end else begin
      for (int p = 0; p < UPD_WIDTH; p++) begin
        if (upd_cond[p]) pht[upd_pidx[p]] <= upd_cnt[p];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb[i] <= '0;
    end else begin
      for (int p = 0; p < UPD_WIDTH; p++) begin
        if (upd_btb[p]) btb[upd_bidx[p]] <= upd_entry[p];
      end
    end
  end

endmodule

// File: doc/bp_gshare_nway.md
# bp_gshare_nway

Parametrised N-wide fetch-side branch predictor: a direct-mapped tagged BTB plus a gshare direction predictor (global history XOR PC indexing a table of 2-bit saturating counters). It sits beside the IF stage and gives a combinational prediction for every fetch slot in the same cycle. Its tables are trained by M resolution ports from EX using the existing `EX_BP_PACKET`. An optional return address stack (RAS) is available for JAL/JALR call/return pairs.

## Interface
- `FETCH_WIDTH`, 2, number of fetch slots predicted per cycle
- `UPD_WIDTH`, 2, number of EX resolution ports
- `BTB_ENTRIES`, 32, BTB depth (power of 2)
- `PHT_ENTRIES`, 256, counter-table depth (power of 2)
- `GHR_BITS`, 8, global history length (≤ log2 `PHT_ENTRIES`)
- `TAG_BITS`, 10, BTB tag width
- `RAS_DEPTH`, 8, RAS entries (used only with `BP_RAS_EN`)
- `clock`  in  1  single clock; all state updates on posedge
- `reset`  in  1  asynchronous, active-low
- `if_pc_in`  in  [FETCH_WIDTH][`XLEN`]  fetch PC per slot
- `inst`  in  [FETCH_WIDTH] `INST`  fetched instruction per slot
- `valid`  in  FETCH_WIDTH  slot valid
- `squash_en`  in  1  pipeline squash; clears RAS
- `ex_bp_packet_in`  in  [UPD_WIDTH] `EX_BP_PACKET`  fields `PC`, `br_en`, `con_br_en`, `con_br_taken`, `tg_pc`
- `bp_taken`  out  FETCH_WIDTH  slot predicted taken
- `bp_pc_out`  out  [FETCH_WIDTH][`XLEN`]  `if_pc_in` passthrough
- `bp_npc_out`  out  [FETCH_WIDTH][`XLEN`]  predicted next PC per slot
- `bp_redirect_en`  out  1  any slot taken
- `bp_redirect_pc`  out  [`XLEN`]  `bp_npc_out` of the lowest taken slot

## Operation
- **Indexing.**
  - BTB index = `PC[2 +: log2 BTB_ENTRIES]`.
  - BTB tag = the next `TAG_BITS` bits above the index.
  - PHT index = `PC[2 +: log2 PHT_ENTRIES]` XOR zero-extended GHR.
- **Prediction** (combinational, per valid slot):
  - Opcode 7'h6F (JAL) or 7'h67 (JALR): taken if the BTB hits.
  - Opcode 7'h63 (BRANCH): taken if the BTB hits and `PHT[idx][1]` is 1.
  - Any other opcode: never taken.
  - Taken slot: `bp_npc_out` = BTB target. Otherwise `bp_npc_out` = PC+4.
  - Slots above the lowest taken slot are forced to `bp_taken`=0, with npc still PC+4.
  - Invalid slots: `bp_taken`=0.
- **Update** (posedge), ports processed in order 0..UPD_WIDTH-1; each port sees GHR/PHT already modified by lower ports in the same cycle.
  - Port inactive when `br_en`=0.
  - `con_br_en`=1:
    - PHT counter saturates up on `con_br_taken`=1, down otherwise (00↔11).
    - GHR ← {GHR[GHR_BITS-2:0], con_br_taken}.
  - Taken, whether unconditional (`con_br_en`=0) or conditional taken: BTB entry ← {valid, tag, `tg_pc`}.
  - Not-taken conditional: BTB is untouched.
  - BTB collision in one cycle: the highest port wins.
  - Two ports on the same PHT entry: both steps apply in sequence.
- **Read-during-write:** prediction uses pre-edge state; an update is visible the cycle after its edge.
- **Reset** (async, while `reset`=0):
  - All BTB valid bits = 0.
  - PHT counters = 2'b01.
  - GHR = 0.
  - RAS count = 0.
  - Resulting outputs: `bp_taken`=0, `bp_redirect_en`=0, `bp_redirect_pc`=0, `bp_npc_out`=PC+4.

## Timing
- Prediction latency: 0 cycles (`if_pc_in` → outputs, combinational).
- Training latency: 1 cycle (resolution at edge N affects prediction from cycle N+1).
- Reset acts mid-cycle without waiting for a clock edge and overrides any same-cycle update.
- No handshakes; the block never stalls IF.

## Configuration
- `BP_RAS_EN` defined: RAS of `RAS_DEPTH` entries, circular.
  - Push: a non-masked valid JAL with rd ∈ {x1,x5} pushes PC+4 at posedge.
  - Pop: a non-masked valid JALR with rs1 ∈ {x1,x5} and rd=x0 pops and is predicted taken to the top of stack, with or without a BTB hit.
  - Overflow overwrites the oldest entry.
  - Pop on empty falls back to the BTB.
  - `squash_en` or reset clears the RAS.
  - Push and pop in the same cycle resolve in slot order.
- `BP_RAS_EN` undefined: no RAS storage; JALR is predicted from the BTB only.

## Structure
- `sys_defs.svh` holds:
  - the `BTB_ENTRY` typedef (valid, tag, target);
  - opcode constants (JAL/JALR/BRANCH);
  - the existing `EX_BP_PACKET` and `INST`.
- One sub-module: `bp_ras`, instantiated only under `BP_RAS_EN`, with ports push/pop/push_data/top/empty/clear.

## Test plan
- **Reset:** `reset`=0 then 1; fetch {0x0,0x4} with `inst`={32'h6F,32'h6F} → `bp_taken`=00, npc {0x4,0x8}, `bp_redirect_en`=0.
- **BTB train:** port0 {br_en=1, con_br_en=0, PC=0x10, tg_pc=0x40}. Next cycle, fetch {0x10,0x14} both JAL → `bp_taken`=01 (slot0), npc {0x40,0x18}, `bp_redirect_pc`=0x40.
- **Gshare aliasing:**
  - Train JAL at 0x20 → tg 0x100.
  - Then resolve conditional 0x24 taken (PHT[9]: 01→10, GHR=1).
  - Fetch BEQ (32'h63) at 0x20 → idx 8^1=9 → taken, npc 0x100.
- **Saturation:**
  - From reset, resolve conditional 0x24 not-taken 3 times → PHT[9]=00, GHR=0.
  - Then fetch BEQ at 0x24 → not taken, npc 0x28.
- **Collision and async reset:**
  - Both ports resolve conditional 0x20 taken in one cycle → PHT[8]=10, PHT[9]=10, GHR=0x03.
  - Drop `reset` mid-cycle → `bp_redirect_en` falls to 0 before the next edge.
- **RAS (`BP_RAS_EN`):**
  - BTB trained 0x40 → 0x200.
  - Fetch JAL x1 (32'hEF) at 0x40 → taken; pushes 0x44.
  - Next cycle, JALR x0,0(x1) (32'h8067) at 0x200 with a BTB miss → npc 0x44.
